// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display scan path: segment codes {a..g}
// (active-low), select patterns {Sel5..Sel0} (active-low) and field limits.
package clock_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'b0000001;
    localparam logic [6:0] SEG_1    = 7'b1001111;
    localparam logic [6:0] SEG_2    = 7'b0010010;
    localparam logic [6:0] SEG_3    = 7'b0000110;
    localparam logic [6:0] SEG_4    = 7'b1001100;
    localparam logic [6:0] SEG_5    = 7'b0100100;
    localparam logic [6:0] SEG_6    = 7'b0100000;
    localparam logic [6:0] SEG_7    = 7'b0001111;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0000100;
    localparam logic [6:0] SEG_DASH = 7'b1111110;

    // Bit i of a select vector is Sel<i>
    localparam logic [5:0] SEL_SEC_T  = 6'b111110;
    localparam logic [5:0] SEL_MIN_O  = 6'b111101;
    localparam logic [5:0] SEL_MIN_T  = 6'b111011;
    localparam logic [5:0] SEL_HOUR_O = 6'b110111;
    localparam logic [5:0] SEL_HOUR_T = 6'b101111;
    localparam logic [5:0] SEL_SEC_O  = 6'b011111;

    typedef logic [2:0] pos_t;

    localparam pos_t POS_SEC_T  = 3'd0;
    localparam pos_t POS_MIN_O  = 3'd1;
    localparam pos_t POS_MIN_T  = 3'd2;
    localparam pos_t POS_HOUR_O = 3'd3;
    localparam pos_t POS_HOUR_T = 3'd4;
    localparam pos_t POS_SEC_O  = 3'd5;

    localparam logic [6:0] HOUR_MAX   = 7'd23;
    localparam logic [6:0] MINSEC_MAX = 7'd59;

endpackage

// File: rtl/seg7_to_digit.sv
// Combinational decode of an active-low {a..g} pattern into a BCD digit,
// a dash flag, or invalid.
module seg7_to_digit
    import clock_disp_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic       dash,
    output logic [3:0] digit
);

    always_comb begin
        valid = 1'b1;
        dash  = 1'b0;
        digit = 4'd0;
        case (seg)
            SEG_0:    digit = 4'd0;
            SEG_1:    digit = 4'd1;
            SEG_2:    digit = 4'd2;
            SEG_3:    digit = 4'd3;
            SEG_4:    digit = 4'd4;
            SEG_5:    digit = 4'd5;
            SEG_6:    digit = 4'd6;
            SEG_7:    digit = 4'd7;
            SEG_8:    digit = 4'd8;
            SEG_9:    digit = 4'd9;
            SEG_DASH: dash  = 1'b1;
            default:  valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Scan-side monitor for the 6-digit multiplexed display: settles each digit,
// assembles frames and republishes them as binary hour/min/sec.
module seg_scan_decoder
    import clock_disp_pkg::*;
#(
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       Sel0,
    input  logic       Sel1,
    input  logic       Sel2,
    input  logic       Sel3,
    input  logic       Sel4,
    input  logic       Sel5,
    output logic [6:0] hour,
    output logic [6:0] min,
    output logic [6:0] sec,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       range_err,
    output logic       blank_frame,
    output logic       stale
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_SCAN    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_PUBLISH = 2'd2;

    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] t7;
        t7 = {3'b000, tens};
        return (t7 << 3) + (t7 << 1) + {3'b000, ones};
    endfunction

    logic [6:0]  seg_p0, seg_p1;
    logic [5:0]  sel_p0, sel_p1;
    logic [CW-1:0] set_cnt;
    logic        pos_ok, same, accept;
    pos_t        pos;
    logic        dig_ok, dig_dash;
    logic [3:0]  dig_val;
    logic [5:0]  seen, dash_f;
    logic [3:0]  digit [6];
    logic [1:0]  state;
    logic        any_dash;
    logic [6:0]  hour_cv, min_cv, sec_cv;
    logic        frame_take, pub_ok;
    logic [TW-1:0] tmo_cnt;

    // Stage p0: pin sampling; p1 holds the previous sample for the settle compare
    always_ff @(posedge clk) begin
        seg_p0 <= {a, b, c, d, e, f, g};
        sel_p0 <= {Sel5, Sel4, Sel3, Sel2, Sel1, Sel0};
        seg_p1 <= seg_p0;
        sel_p1 <= sel_p0;
    end

    always_comb begin
        pos_ok = 1'b1;
        pos    = POS_SEC_T;
        case (sel_p0)
            SEL_SEC_T:  pos = POS_SEC_T;
            SEL_MIN_O:  pos = POS_MIN_O;
            SEL_MIN_T:  pos = POS_MIN_T;
            SEL_HOUR_O: pos = POS_HOUR_O;
            SEL_HOUR_T: pos = POS_HOUR_T;
            SEL_SEC_O:  pos = POS_SEC_O;
            default:    pos_ok = 1'b0;
        endcase
    end

    seg7_to_digit u_dec (
        .seg   (seg_p0),
        .valid (dig_ok),
        .dash  (dig_dash),
        .digit (dig_val)
    );

    // Count saturates at SETTLE so a steady digit is accepted exactly once
    assign same   = (sel_p0 == sel_p1) && (seg_p0 == seg_p1);
    assign accept = pos_ok && same && (set_cnt == CW'(SETTLE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_cnt <= '0;
        end else if (!pos_ok) begin
            set_cnt <= '0;
        end else if (!same || set_cnt == '0) begin
            set_cnt <= CW'(1);
        end else if (set_cnt < CW'(SETTLE)) begin
            set_cnt <= set_cnt + CW'(1);
        end
    end

    assign frame_take = (state == ST_SCAN) && (seen == 6'h3F);

    // Accepts landing on the frame_take edge belong to the next frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen    <= '0;
            dash_f  <= '0;
            seg_err <= 1'b0;
        end else begin
            seg_err <= 1'b0;
            if (frame_take) begin
                seen   <= '0;
                dash_f <= '0;
            end
            if (accept) begin
                if (dig_ok) begin
                    seen[pos]   <= 1'b1;
                    dash_f[pos] <= dig_dash;
                end else begin
                    seen[pos] <= 1'b0;
                    seg_err   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && dig_ok) digit[pos] <= dig_val;
    end

    // Stage p1: frame snapshot converted to binary as the FSM enters CONVERT
    always_ff @(posedge clk) begin
        if (frame_take) begin
            hour_cv <= bcd_to_bin(digit[POS_HOUR_T], digit[POS_HOUR_O]);
            min_cv  <= bcd_to_bin(digit[POS_MIN_T],  digit[POS_MIN_O]);
            sec_cv  <= bcd_to_bin(digit[POS_SEC_T],  digit[POS_SEC_O]);
        end
    end

    assign pub_ok = (state == ST_CONVERT) && !any_dash && (hour_cv <= HOUR_MAX) &&
                    (min_cv <= MINSEC_MAX) && (sec_cv <= MINSEC_MAX);

    // Stage p2: publish decision; pulses are visible during PUBLISH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_SCAN;
            any_dash    <= 1'b0;
            hour        <= '0;
            min         <= '0;
            sec         <= '0;
            frame_valid <= 1'b0;
            range_err   <= 1'b0;
            blank_frame <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            range_err   <= 1'b0;
            blank_frame <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (frame_take) begin
                        state    <= ST_CONVERT;
                        any_dash <= |dash_f;
                    end
                end
                ST_CONVERT: begin
                    state <= ST_PUBLISH;
                    if (any_dash) begin
                        blank_frame <= 1'b1;
                    end else if (!pub_ok) begin
                        range_err <= 1'b1;
                    end else begin
                        hour        <= hour_cv;
                        min         <= min_cv;
                        sec         <= sec_cv;
                        frame_valid <= 1'b1;
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (pub_ok) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TW'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign stale = (tmo_cnt == TW'(TIMEOUT));

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans frames the way the display
// driver does (select first, segments one clock later) and checks results.
module tb_seg_scan_decoder;

    typedef logic [6:0] codes_t [6];

    logic       clk = 1'b0;
    logic       rst;
    logic       a, b, c, d, e, f, g;
    logic       Sel0, Sel1, Sel2, Sel3, Sel4, Sel5;
    logic [6:0] hour, min, sec;
    logic       frame_valid, seg_err, range_err, blank_frame, stale;

    logic [6:0] seg_drv;
    logic [5:0] sel_drv;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         fv_n = 0, se_n = 0, re_n = 0, bf_n = 0;
    int         last_fv_cyc = 0;
    int         t_step0 = 0;

    assign {a, b, c, d, e, f, g} = seg_drv;
    assign {Sel5, Sel4, Sel3, Sel2, Sel1, Sel0} = sel_drv;

    seg_scan_decoder #(.SETTLE(3), .TIMEOUT(4096)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .e           (e),
        .f           (f),
        .g           (g),
        .Sel0        (Sel0),
        .Sel1        (Sel1),
        .Sel2        (Sel2),
        .Sel3        (Sel3),
        .Sel4        (Sel4),
        .Sel5        (Sel5),
        .hour        (hour),
        .min         (min),
        .sec         (sec),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .range_err   (range_err),
        .blank_frame (blank_frame),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_n <= fv_n + 1;
            last_fv_cyc <= cyc;
        end
        if (seg_err)     se_n <= se_n + 1;
        if (range_err)   re_n <= re_n + 1;
        if (blank_frame) bf_n <= bf_n + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] code(input int v);
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    // Index = select line: 0 sec tens, 1 min ones, 2 min tens, 3 hour ones, 4 hour tens, 5 sec ones
    function automatic codes_t mk(input int h, input int m, input int s);
        codes_t cd;
        cd[0] = code(s / 10);
        cd[1] = code(m % 10);
        cd[2] = code(m / 10);
        cd[3] = code(h % 10);
        cd[4] = code(h / 10);
        cd[5] = code(s % 10);
        return cd;
    endfunction

    task automatic drive_digit(input int idx, input logic [6:0] cd, input int ncyc);
        t_step0 = cyc;
        sel_drv = ~(6'b000001 << idx);
        @(posedge clk); #1;
        seg_drv = cd;
        repeat (ncyc - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        sel_drv = 6'h3F;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic scan(input codes_t cd, input int ncyc, input int first, input int last);
        for (int i = first; i <= last; i++) drive_digit(i, cd[i], ncyc);
    endtask

    initial begin
        codes_t cd;
        int fv0, se0, re0, bf0, k;

        rst = 1'b1;
        seg_drv = 7'h7F;
        sel_drv = 6'h3F;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hour", hour, 0);
        check("rst_min", min, 0);
        check("rst_sec", sec, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_stale", stale, 0);
        rst = 1'b0;
        idle(2);

        // Normal frame 12:34:56, 4 cycles per digit
        fv0 = fv_n; se0 = se_n;
        scan(mk(12, 34, 56), 4, 0, 5);
        idle(8);
        check("f1_fv", fv_n - fv0, 1);
        check("f1_hour", hour, 12);
        check("f1_min", min, 34);
        check("f1_sec", sec, 56);
        check("f1_latency", last_fv_cyc - t_step0, 7);
        check("f1_segerr", se_n - se0, 0);

        // 2 cycles per digit never settles
        fv0 = fv_n; se0 = se_n;
        scan(mk(1, 2, 3), 2, 0, 5);
        idle(8);
        check("fast_fv", fv_n - fv0, 0);
        check("fast_segerr", se_n - se0, 0);
        check("fast_hour", hour, 12);

        // Undecodable hour ones, then rescan the digit alone
        fv0 = fv_n; se0 = se_n;
        cd = mk(7, 8, 9);
        cd[3] = 7'b1111111;
        scan(cd, 4, 0, 5);
        idle(8);
        check("bad_segerr", se_n - se0, 1);
        check("bad_fv", fv_n - fv0, 0);
        drive_digit(3, code(7), 4);
        idle(8);
        check("fix_fv", fv_n - fv0, 1);
        check("fix_hour", hour, 7);
        check("fix_min", min, 8);
        check("fix_sec", sec, 9);

        // Restore 12:34:56, then out-of-range frames
        scan(mk(12, 34, 56), 4, 0, 5);
        idle(8);
        fv0 = fv_n; re0 = re_n;
        scan(mk(25, 0, 0), 4, 0, 5);
        idle(8);
        check("hr25_rangeerr", re_n - re0, 1);
        check("hr25_fv", fv_n - fv0, 0);
        check("hr25_hour", hour, 12);
        check("hr25_min", min, 34);
        scan(mk(10, 60, 0), 4, 0, 5);
        idle(8);
        check("min60_rangeerr", re_n - re0, 2);
        check("min60_sec", sec, 56);

        // All dashes
        fv0 = fv_n; bf0 = bf_n;
        for (int i = 0; i < 6; i++) cd[i] = 7'b1111110;
        scan(cd, 4, 0, 5);
        idle(8);
        check("dash_blank", bf_n - bf0, 1);
        check("dash_fv", fv_n - fv0, 0);
        check("dash_hour", hour, 12);

        // Timeout: stale exactly 4096 cycles after the last frame_valid
        check("pre_stale", stale, 0);
        k = 0;
        while (!stale && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("stale_set", stale, 1);
        check("stale_delay", cyc - last_fv_cyc, 4096);
        @(posedge clk); #1;

        fv0 = fv_n;
        scan(mk(8, 15, 42), 4, 0, 5);
        idle(8);
        check("recover_fv", fv_n - fv0, 1);
        check("recover_stale", stale, 0);
        check("recover_hour", hour, 8);

        // Reset after three digits of 23:59:59
        scan(mk(23, 59, 59), 4, 0, 2);
        rst = 1'b1;
        #2;
        check("midrst_hour", hour, 0);
        check("midrst_min", min, 0);
        check("midrst_sec", sec, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        fv0 = fv_n;
        scan(mk(23, 59, 59), 4, 0, 5);
        idle(8);
        check("max_fv", fv_n - fv0, 1);
        check("max_hour", hour, 23);
        check("max_min", min, 59);
        check("max_sec", sec, 59);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
